// File: rtl/cpu_arb_pkg.sv
// Shared types and default sizes for the RAM port arbiter between the CPU and the front-panel programmer.
package cpu_arb_pkg;

   localparam int ARB_ADDR_W       = 4;
   localparam int ARB_DATA_W       = 8;
   localparam int ARB_DRAIN_CYCLES = 2;
   localparam int ARB_TIMEOUT      = 255;

   typedef enum logic [2:0] {
      ST_CPU_OWN  = 3'd0,
      ST_WAIT_BND = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_PG_IDLE  = 3'd3,
      ST_PG_ACC   = 3'd4,
      ST_RELEASE  = 3'd5
   } arb_state_e;

endpackage

// File: rtl/arb_down_counter.sv
// Loadable down-counter with zero flag; serves both the drain wait and the boundary-wait timeout.
module arb_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ram_port_arbiter.sv
// Hands the RAM port between the CPU and the front-panel programmer, stalling the CPU at an instruction boundary.
// Optional boundary-wait timeout with sticky flag is enabled by defining RAM_ARB_TIMEOUT_EN.
//
// state     | meaning
// CPU_OWN   | CPU drives the RAM port, no session
// WAIT_BND  | session requested, waiting for CPU fetch T0
// DRAIN     | CPU stalled, letting delayed control lines settle
// PG_IDLE   | programmer granted, waiting for a strobe
// PG_ACC    | single programmer access on the port
// RELEASE   | one idle cycle before the CPU resumes
module ram_port_arbiter
   import cpu_arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int DRAIN_CYCLES = ARB_DRAIN_CYCLES,
   parameter int TIMEOUT      = ARB_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_boundary,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_re,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              pg_session,
   input  logic              pg_strobe,
   input  logic              pg_we,
   input  logic [ADDR_W-1:0] pg_addr,
   input  logic [DATA_W-1:0] pg_wdata,
   output logic              pg_grant,
   output logic              pg_ack,
   output logic [DATA_W-1:0] pg_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              timeout_flag
);

   // Counter is sized for the larger of the two loads it has to hold.
   localparam int CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);
`ifdef RAM_ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);
`endif

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_W-1:0] acc_wdata_q, acc_wdata_d;
   logic              acc_we_q, acc_we_d;
   logic [DATA_W-1:0] pg_rdata_q, pg_rdata_d;
   logic              pg_ack_q, pg_ack_d;
   logic              cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]  cnt_val;
`ifdef RAM_ARB_TIMEOUT_EN
   logic              timeout_flag_q, timeout_flag_d;
`endif

   arb_down_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d     = state_q;
      acc_addr_d  = acc_addr_q;
      acc_wdata_d = acc_wdata_q;
      acc_we_d    = acc_we_q;
      pg_rdata_d  = pg_rdata_q;
      pg_ack_d    = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      cnt_val     = DRAIN_LD;
`ifdef RAM_ARB_TIMEOUT_EN
      timeout_flag_d = timeout_flag_q;
`endif
      case (state_q)
         ST_CPU_OWN: begin
            if (pg_session) begin
               state_d = ST_WAIT_BND;
`ifdef RAM_ARB_TIMEOUT_EN
               cnt_load = 1'b1;
               cnt_val  = TIMEOUT_LD;
`endif
            end
         end
         ST_WAIT_BND: begin
            if (!pg_session) begin
               state_d = ST_CPU_OWN;
            end else if (cpu_boundary) begin
               state_d  = ST_DRAIN;
               cnt_load = 1'b1;
`ifdef RAM_ARB_TIMEOUT_EN
            end else if (cnt_zero) begin
               state_d        = ST_DRAIN;
               cnt_load       = 1'b1;
               timeout_flag_d = 1'b1;
            end else begin
               cnt_dec = 1'b1;
`endif
            end
         end
         ST_DRAIN: begin
            cnt_dec = 1'b1;
            if (!pg_session)   state_d = ST_RELEASE;
            else if (cnt_zero) state_d = ST_PG_IDLE;
         end
         ST_PG_IDLE: begin
            if (!pg_session) begin
               state_d = ST_RELEASE;
            end else if (pg_strobe) begin
               state_d     = ST_PG_ACC;
               acc_addr_d  = pg_addr;
               acc_wdata_d = pg_wdata;
               acc_we_d    = pg_we;
            end
         end
         ST_PG_ACC: begin
            // The access always finishes, even if the session drops this cycle.
            pg_ack_d = 1'b1;
            if (!acc_we_q) pg_rdata_d = ram_rdata;
            state_d = pg_session ? ST_PG_IDLE : ST_RELEASE;
         end
         ST_RELEASE: state_d = ST_CPU_OWN;
         default:    state_d = ST_CPU_OWN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_CPU_OWN;
         acc_addr_q  <= '0;
         acc_wdata_q <= '0;
         acc_we_q    <= 1'b0;
         pg_rdata_q  <= '0;
         pg_ack_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_addr_q  <= acc_addr_d;
         acc_wdata_q <= acc_wdata_d;
         acc_we_q    <= acc_we_d;
         pg_rdata_q  <= pg_rdata_d;
         pg_ack_q    <= pg_ack_d;
      end
   end

`ifdef RAM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) timeout_flag_q <= 1'b0;
      else     timeout_flag_q <= timeout_flag_d;
   end
   assign timeout_flag = timeout_flag_q;
`else
   assign timeout_flag = 1'b0;
`endif

   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      case (state_q)
         ST_CPU_OWN, ST_WAIT_BND: begin
            ram_we = cpu_we;
            ram_re = cpu_re;
         end
         ST_PG_ACC: begin
            ram_addr  = acc_addr_q;
            ram_wdata = acc_wdata_q;
            ram_we    = acc_we_q;
            ram_re    = ~acc_we_q;
         end
         default: ;
      endcase
   end

   assign cpu_stall = (state_q == ST_DRAIN) || (state_q == ST_PG_IDLE) ||
                      (state_q == ST_PG_ACC) || (state_q == ST_RELEASE);
   assign pg_grant  = (state_q == ST_PG_IDLE) || (state_q == ST_PG_ACC);
   assign pg_ack    = pg_ack_q;
   assign pg_rdata  = pg_rdata_q;
   assign cpu_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: RAM model, shadow memory and spec timing rules; covers RAM_ARB_TIMEOUT_EN when defined.
module tb_ram_port_arbiter;

   localparam int DRAIN = 2;
`ifdef RAM_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 4;
   localparam int FIRST_DLY  = 2;
`else
   localparam int TB_TIMEOUT = 255;
   localparam int FIRST_DLY  = 5;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_boundary, cpu_we, cpu_re;
   logic [3:0] cpu_addr;
   logic [7:0] cpu_wdata, cpu_rdata;
   logic       cpu_stall;
   logic       pg_session, pg_strobe, pg_we;
   logic [3:0] pg_addr;
   logic [7:0] pg_wdata, pg_rdata;
   logic       pg_grant, pg_ack;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       ram_we, ram_re;
   logic [7:0] ram_rdata;
   logic       timeout_flag;

   logic [7:0] ram_mem [16];
   logic [7:0] ref_mem [16];
   logic [7:0] last_rd;
   int         n_chk = 0;
   int         n_fail = 0;

   ram_port_arbiter #(
      .ADDR_W(4), .DATA_W(8), .DRAIN_CYCLES(DRAIN), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .cpu_boundary(cpu_boundary), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .pg_session(pg_session), .pg_strobe(pg_strobe), .pg_we(pg_we),
      .pg_addr(pg_addr), .pg_wdata(pg_wdata), .pg_grant(pg_grant), .pg_ack(pg_ack),
      .pg_rdata(pg_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata),
      .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   // RAM samples on the falling edge
   always @(negedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic open_session(input int dly);
      cpu_we = 1'b0;
      cpu_boundary = 1'b0;
      pg_session = 1'b1;
      tick();
      for (int i = 0; i < dly; i++) begin
         chk("wait_stall", cpu_stall, 1'b0);
         tick();
      end
      cpu_boundary = 1'b1;
      tick();
      cpu_boundary = 1'b0;
      cpu_we = 1'b1;
      chk("bnd_stall", cpu_stall, 1'b1);
      for (int i = 0; i < DRAIN; i++) begin
         chk("drain_grant", pg_grant, 1'b0);
         chk("drain_we", ram_we, 1'b0);
         chk("drain_stall", cpu_stall, 1'b1);
         tick();
      end
      chk("grant_up", pg_grant, 1'b1);
   endtask

   task automatic close_session();
      pg_session = 1'b0;
      pg_strobe = 1'b1;
      pg_we = 1'b1;
      pg_addr = 4'($urandom);
      tick();
      pg_strobe = 1'b0;
      chk("rel_stall", cpu_stall, 1'b1);
      chk("rel_grant", pg_grant, 1'b0);
      chk("rel_we", ram_we, 1'b0);
      tick();
      cpu_we = 1'b0;
      chk("cpu_back_stall", cpu_stall, 1'b0);
      chk("cpu_back_ack", pg_ack, 1'b0);
   endtask

   task automatic access(input bit we, input logic [3:0] a, input logic [7:0] d,
                         input bit dbl, input bit drop);
      logic [7:0] exp_rd;
      pg_strobe = 1'b1;
      pg_we = we;
      pg_addr = a;
      pg_wdata = d;
      tick();
      pg_strobe = dbl;
      pg_addr = ~a;
      pg_wdata = ~d;
      pg_we = ~we;
      if (drop) pg_session = 1'b0;
      chk("acc_addr", ram_addr, a);
      chk("acc_we", ram_we, we);
      chk("acc_re", ram_re, !we);
      if (we) chk("acc_wdata", ram_wdata, d);
      chk("acc_ack_early", pg_ack, 1'b0);
      chk("acc_grant", pg_grant, 1'b1);
      tick();
      pg_strobe = 1'b0;
      exp_rd = we ? last_rd : ref_mem[a];
      if (we) ref_mem[a] = d;
      last_rd = exp_rd;
      chk("ack", pg_ack, 1'b1);
      chk("pg_rdata", pg_rdata, exp_rd);
      chk("ack_grant", pg_grant, !drop);
      chk("ack_stall", cpu_stall, 1'b1);
      if (drop) begin
         chk("drop_we", ram_we, 1'b0);
         chk("drop_re", ram_re, 1'b0);
         tick();
         cpu_we = 1'b0;
         chk("drop_stall", cpu_stall, 1'b0);
         chk("drop_grant", pg_grant, 1'b0);
      end else begin
         tick();
         chk("ack_single", pg_ack, 1'b0);
         chk("idle_grant", pg_grant, 1'b1);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram_mem[i] = 8'h00;
         ref_mem[i] = 8'h00;
      end
      last_rd = 8'h00;
      ram_rdata = 8'h00;
      rst = 1'b1;
      cpu_boundary = 1'b0; cpu_we = 1'b0; cpu_re = 1'b0;
      cpu_addr = 4'h0; cpu_wdata = 8'h00;
      pg_session = 1'b0; pg_strobe = 1'b0; pg_we = 1'b0;
      pg_addr = 4'h0; pg_wdata = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_stall", cpu_stall, 1'b0);
      chk("rst_grant", pg_grant, 1'b0);
      chk("rst_ack", pg_ack, 1'b0);
      chk("rst_rdata", pg_rdata, 8'h00);
      chk("rst_tflag", timeout_flag, 1'b0);
      rst = 1'b0;
      tick();

      cpu_addr = 4'h3; cpu_re = 1'b1;
      #1;
      chk("own_addr", ram_addr, 4'h3);
      chk("own_re", ram_re, 1'b1);
      chk("own_stall", cpu_stall, 1'b0);
      chk("own_grant", pg_grant, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cpu_addr = 4'($urandom);
         cpu_wdata = 8'($urandom);
         cpu_we = 1'($urandom);
         cpu_re = 1'($urandom);
         #1;
         chk("pass_addr", ram_addr, cpu_addr);
         chk("pass_wdata", ram_wdata, cpu_wdata);
         chk("pass_we", ram_we, cpu_we);
         chk("pass_re", ram_re, cpu_re);
         chk("pass_rdata", cpu_rdata, ram_rdata);
         if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
         tick();
      end
      cpu_we = 1'b0;

      open_session(FIRST_DLY);
      access(1'b1, 4'hA, 8'h5C, 1'b0, 1'b0);
      access(1'b0, 4'hA, 8'h00, 1'b1, 1'b0);
      chk("rt_5c", last_rd, 8'h5C);
      close_session();

      for (int s = 0; s < 10; s++) begin
         int n;
         bit drop;
         open_session($urandom_range(0, 3));
         n = $urandom_range(1, 5);
         drop = 1'b0;
         for (int k = 0; k < n; k++) begin
            drop = (k == n - 1) && ($urandom_range(0, 1) == 1);
            access(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), drop);
         end
         if (!drop) close_session();
      end

      open_session(1);
      access(1'b0, 4'h6, 8'h00, 1'b0, 1'b1);

      open_session(0);
      access(1'b1, 4'h5, 8'hA5, 1'b0, 1'b0);
      access(1'b0, 4'h5, 8'h00, 1'b0, 1'b0);
      chk("pre_rst_rdata", pg_rdata, 8'hA5);
      pg_strobe = 1'b1; pg_we = 1'b0; pg_addr = 4'h5;
      tick();
      pg_strobe = 1'b0;
      #2;
      rst = 1'b1;
      pg_session = 1'b0;
      cpu_we = 1'b1; cpu_addr = 4'h9; cpu_wdata = 8'h3E;
      #1;
      chk("arst_we", ram_we, 1'b1);
      chk("arst_addr", ram_addr, 4'h9);
      chk("arst_grant", pg_grant, 1'b0);
      chk("arst_rdata", pg_rdata, 8'h00);
      chk("arst_stall", cpu_stall, 1'b0);
      ref_mem[9] = 8'h3E;
      #3;
      rst = 1'b0;
      cpu_we = 1'b0;
      tick();
      last_rd = 8'h00;
      open_session(0);
      access(1'b0, 4'h9, 8'h00, 1'b0, 1'b0);
      close_session();

`ifdef RAM_ARB_TIMEOUT_EN
      pg_session = 1'b1;
      cpu_boundary = 1'b0;
      tick();
      for (int i = 0; i < TB_TIMEOUT; i++) begin
         chk("to_wait_stall", cpu_stall, 1'b0);
         chk("to_wait_flag", timeout_flag, 1'b0);
         tick();
      end
      chk("to_forced_stall", cpu_stall, 1'b1);
      chk("to_flag", timeout_flag, 1'b1);
      repeat (DRAIN) tick();
      chk("to_grant", pg_grant, 1'b1);
      close_session();
      repeat (3) tick();
      chk("to_sticky", timeout_flag, 1'b1);
      rst = 1'b1;
      #2;
      chk("to_rst_clear", timeout_flag, 1'b0);
      rst = 1'b0;
      tick();
`else
      pg_session = 1'b1;
      cpu_boundary = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("nto_stall", cpu_stall, 1'b0);
         chk("nto_flag", timeout_flag, 1'b0);
      end
      pg_session = 1'b0;
      tick();
      chk("nto_back", cpu_stall, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the 16x8 RAM port between the CPU core (MAR/RR/RW path) and the front-panel programmer used to key in programs by hand.
- The CPU owns the port by default. The programmer opens a session; the arbiter stalls the CPU at an instruction boundary, drains in-flight control, grants the port, and serves single-word read/write strobes. On session close it hands the port back.
- Sits between the control/MAR/RAM datapath and the panel logic. Drives the CPU clock-enable stall.

Parameters:
- ADDR_W, 4, RAM address width (matches MAR).
- DATA_W, 8, RAM/bus data width.
- DRAIN_CYCLES, 2, idle cycles after stall before grant; covers control-line delay stages; legal range 1..15.
- TIMEOUT, 255, boundary-wait limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_boundary  in  1  CPU is at fetch T0, so stalling is safe.
- cpu_addr  in  ADDR_W  MAR output.
- cpu_wdata  in  DATA_W  bus value for CPU writes.
- cpu_we  in  1  RW control.
- cpu_re  in  1  RR control.
- cpu_rdata  out  DATA_W  ram_rdata passthrough, combinational.
- cpu_stall  out  1  freezes the CPU clock enable.
- pg_session  in  1  programmer requests ownership (level).
- pg_strobe  in  1  one-cycle access request.
- pg_we  in  1  1 = write, 0 = read; sampled with pg_strobe.
- pg_addr  in  ADDR_W  programmer address.
- pg_wdata  in  DATA_W  programmer write data.
- pg_grant  out  1  programmer owns the port.
- pg_ack  out  1  one-cycle access-done pulse.
- pg_rdata  out  DATA_W  registered read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- timeout_flag  out  1  sticky; optional feature only.

Behaviour:
- Reset (async): state CPU_OWN. cpu_stall=0, pg_grant=0, pg_ack=0, pg_rdata=0, internal pg address/data/we registers=0, counter=0, timeout_flag=0.
- FSM states: CPU_OWN, WAIT_BND, DRAIN, PG_IDLE, PG_ACC, RELEASE.
- CPU_OWN: if pg_session=1, go to WAIT_BND.
- WAIT_BND:
  - pg_session=0: return to CPU_OWN.
  - cpu_boundary=1: go to DRAIN, assert cpu_stall, load counter with DRAIN_CYCLES-1.
- DRAIN:
  - Counter decrements each cycle; at 0 go to PG_IDLE.
  - pg_session=0 at any point: go to RELEASE.
- PG_IDLE:
  - pg_session=0: go to RELEASE (same-cycle pg_strobe ignored).
  - Else pg_strobe=1: register pg_addr, pg_wdata, pg_we; go to PG_ACC.
- PG_ACC: exactly one cycle. Capture ram_rdata into pg_rdata on reads only; pg_rdata holds on writes. Pulse pg_ack for the following cycle. Return to PG_IDLE, or to RELEASE if pg_session=0; the access always completes first.
- RELEASE: one cycle with the port idle; cpu_stall drops on exit to CPU_OWN.
- cpu_stall is high in DRAIN, PG_IDLE, PG_ACC and RELEASE.
- pg_grant is high in PG_IDLE and PG_ACC.
- pg_strobe is ignored outside PG_IDLE. A second strobe before pg_ack is dropped.
- Port mux (combinational from state):
  - CPU_OWN, WAIT_BND: ram_* = cpu_*.
  - DRAIN, PG_IDLE, RELEASE: ram_we=0, ram_re=0, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
  - PG_ACC: ram_addr and ram_wdata from the registered pg values; ram_we = registered pg_we; ram_re = ~registered pg_we.
- Latency: pg_strobe sampled at edge N. Access occurs in cycle N+1; RAM samples on the falling edge of that cycle. pg_ack and valid pg_rdata appear in cycle N+2.
- Reset mid-write: ram_we drops immediately with state; the write is not guaranteed.

Optional Feature:
- Macro: RAM_ARB_TIMEOUT_EN.
- Defined: WAIT_BND counts cycles. When the count reaches TIMEOUT, the arbiter forces entry to DRAIN and sets timeout_flag. The flag clears only on rst.
- Undefined: WAIT_BND waits indefinitely and timeout_flag is tied to 0.

Decomposition:
- Package cpu_arb_pkg holds:
  - state enum (6 states, 3-bit encoding);
  - ADDR_W and DATA_W defaults;
  - DRAIN_CYCLES default.
- One sub-module, arb_down_counter, is shared by the drain count and the timeout count. It is loadable, decrements, and has a zero flag.

Test Plan:
- CPU ownership: reset, pg_session=0, cpu_addr=4'h3, cpu_re=1 -> ram_addr=3, ram_re=1, cpu_stall=0, pg_grant=0.
- Grant sequence: pg_session=1, cpu_boundary low 5 cycles then high -> cpu_stall rises on the boundary edge; pg_grant rises 2 cycles later; ram_we=0 throughout DRAIN.
- Write/read round trip:
  - Write: pg_strobe with we=1, addr=4'hA, wdata=8'h5C -> ram_we=1, ram_addr=A for one cycle; pg_ack pulses 2 cycles after strobe.
  - Read: read of A -> pg_rdata=8'h5C when pg_ack pulses.
- Session drop during access: drop pg_session in the PG_ACC cycle -> access completes and pg_ack pulses; RELEASE for 1 cycle; cpu_stall=0 the next cycle.
- Async reset: assert rst during PG_ACC -> state CPU_OWN, ram_we follows cpu_we, pg_grant=0, pg_rdata=0.
- Timeout (macro on, TIMEOUT=4): cpu_boundary held 0 -> cpu_stall forced after 4 WAIT_BND cycles, timeout_flag=1 and sticky until rst.
